// File: rtl/mux16_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux16_rr_arbiter (with helper Mux16bit)
//  Purpose  : Round-robin arbiter with burst allowance that shares one 16-bit
//             2:1 mux between two valid/ready requesters and registers the
//             selected beat into a single output stage.
//  Revision : 1.0  initial release
// ============================================================================

// Plain 16-bit 2:1 mux: the datapath shared by both requesters.
module Mux16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        sel,
   output logic [15:0] y
);
   assign y = sel ? b : a;
endmodule

module mux16_rr_arbiter #(
   parameter int WIDTH     = 16,   // the shared mux is 16 bits wide, so keep 16
   parameter int BURST_MAX = 2     // consecutive wins allowed while the other waits
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   output logic             b_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   input  logic             out_ready,
   output logic             sel
);

   localparam int CW = $clog2(BURST_MAX + 1);
   localparam logic [CW-1:0] BURST_LIM = CW'(BURST_MAX);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] OWN_A = 2'd1;
   localparam logic [1:0] OWN_B = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    burst_cnt;
   logic             last_src;
   logic             slot;
   logic             win_valid;
   logic             win_src;
   logic [WIDTH-1:0] mux_y;

   // The output register can take a new beat when empty or being drained.
   assign slot = ~out_valid | out_ready;

   // Pick the winner for this cycle from owner, burst count and last source.
   always_comb begin
      win_valid = 1'b0;
      win_src   = 1'b0;
      case (state)
         OWN_A: begin
            if (a_valid && (burst_cnt < BURST_LIM || !b_valid)) begin
               win_valid = 1'b1;
               win_src   = 1'b0;
            end else if (b_valid) begin
               win_valid = 1'b1;
               win_src   = 1'b1;
            end
         end
         OWN_B: begin
            if (b_valid && (burst_cnt < BURST_LIM || !a_valid)) begin
               win_valid = 1'b1;
               win_src   = 1'b1;
            end else if (a_valid) begin
               win_valid = 1'b1;
               win_src   = 1'b0;
            end
         end
         default: begin
            // No owner: alternate away from whoever went last when both ask.
            if (a_valid && b_valid) begin
               win_valid = 1'b1;
               win_src   = ~last_src;
            end else if (a_valid) begin
               win_valid = 1'b1;
               win_src   = 1'b0;
            end else if (b_valid) begin
               win_valid = 1'b1;
               win_src   = 1'b1;
            end
         end
      endcase
   end

   // Handshakes and mux select; all forced low while reset is asserted.
   assign sel     = rst_n & (win_valid ? win_src : out_src);
   assign a_ready = rst_n & slot & win_valid & ~win_src & a_valid;
   assign b_ready = rst_n & slot & win_valid &  win_src & b_valid;

   Mux16bit datapath (
      .a   (a_data),
      .b   (b_data),
      .sel (sel),
      .y   (mux_y)
   );

   // Output register plus arbitration state; everything freezes under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= 1'b0;
         state     <= IDLE;
         burst_cnt <= '0;
         last_src  <= 1'b1;
      end else if (slot) begin
         if (win_valid) begin
            out_data  <= mux_y;
            out_src   <= win_src;
            out_valid <= 1'b1;
            last_src  <= win_src;
            if (state == (win_src ? OWN_B : OWN_A)) begin
               if (burst_cnt != BURST_LIM)
                  burst_cnt <= burst_cnt + 1'b1;
            end else begin
               state     <= win_src ? OWN_B : OWN_A;
               burst_cnt <= CW'(1);
            end
         end else begin
            // Nobody asking: drop ownership so the next contest starts fresh.
            out_valid <= 1'b0;
            state     <= IDLE;
            burst_cnt <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mux16_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux16_rr_arbiter
//  Purpose  : Scoreboard bench for mux16_rr_arbiter: directed scenarios plus
//             randomized traffic against a behavioural arbitration model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux16_rr_arbiter;

   localparam int BURST = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_valid, b_valid, a_ready, b_ready;
   logic [15:0] a_data, b_data, out_data;
   logic        out_valid, out_src, out_ready, sel;

   int errors = 0;
   int checks = 0;

   typedef struct { logic src; logic [15:0] data; } beat_t;
   beat_t sbq[$];
   logic  seen_src[$];

   // behavioural model: streak of the current owner, plus output-register view
   int  m_len;       // wins in a row by m_owner; 0 means nobody owns
   bit  m_owner, m_last, m_ov, m_src;
   bit  chk_en;
   bit  a_taken, b_taken;
   bit  m_slot, w_ok, w, own_v, oth_v;

   mux16_rr_arbiter #(.WIDTH(16), .BURST_MAX(BURST)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
      .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
      .out_ready(out_ready), .sel(sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_len = 0; m_owner = 0; m_last = 1; m_ov = 0; m_src = 0;
      sbq.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      chk_en = 0;
      rst_n  = 0;
      @(negedge clk);
      model_reset();
      rst_n  = 1;
      chk_en = 1;
   endtask

   // Reference model: decide the winner from the rules, check handshakes, push expected beats.
   always begin
      @(negedge clk); #3;
      if (rst_n && chk_en) begin
         m_slot = !m_ov || out_ready;
         w_ok = 0; w = 0;
         if (m_len == 0) begin
            if (a_valid && b_valid) begin w_ok = 1; w = !m_last; end
            else if (a_valid)       begin w_ok = 1; w = 0; end
            else if (b_valid)       begin w_ok = 1; w = 1; end
         end else begin
            own_v = m_owner ? b_valid : a_valid;
            oth_v = m_owner ? a_valid : b_valid;
            if (own_v && (m_len < BURST || !oth_v)) begin w_ok = 1; w = m_owner; end
            else if (oth_v)                         begin w_ok = 1; w = !m_owner; end
         end
         chk("out_valid", out_valid, m_ov);
         chk("a_ready", a_ready, m_slot && w_ok && !w);
         chk("b_ready", b_ready, m_slot && w_ok && w);
         chk("sel", sel, w_ok ? w : m_src);
         a_taken = m_slot && w_ok && !w;
         b_taken = m_slot && w_ok && w;
         if (m_slot) begin
            if (w_ok) begin
               sbq.push_back('{src: w, data: (w ? b_data : a_data)});
               m_ov = 1; m_src = w; m_last = w;
               if (m_len > 0 && w == m_owner) m_len = (m_len + 1 > BURST) ? BURST : m_len + 1;
               else begin m_owner = w; m_len = 1; end
            end else begin
               m_ov = 0; m_len = 0;
            end
         end
      end else begin
         a_taken = 0; b_taken = 0;
      end
   end

   // Monitor: every beat the consumer takes must match the oldest expected beat.
   always begin
      beat_t e;
      @(negedge clk); #3;
      if (rst_n && chk_en && out_valid && out_ready) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got src=%0d data=%h expected none", out_src, out_data);
         end else begin
            e = sbq.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_src", out_src, e.src);
         end
         seen_src.push_back(out_src);
      end
   end

   initial begin
      logic exp3[5];
      logic exp5[4];
      exp3 = '{0, 0, 1, 1, 0};
      exp5 = '{0, 0, 1, 0};
      a_valid = 0; b_valid = 0; a_data = 0; b_data = 0; out_ready = 1;
      chk_en = 0; rst_n = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1; chk_en = 1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_src", out_src, 0);

      // A alone
      @(negedge clk);
      a_valid = 1; a_data = 16'h1234;
      #3;
      chk("t2_a_ready", a_ready, 1);
      chk("t2_sel", sel, 0);
      @(negedge clk);
      a_valid = 0;
      #1;
      chk("t2_out_data", out_data, 16'h1234);
      chk("t2_out_src", out_src, 0);

      // both valid from a fresh reset: A,A,B,B,A
      a_valid = 0; b_valid = 0;
      do_reset();
      seen_src.delete();
      a_valid = 1; a_data = 16'hAAAA; b_valid = 1; b_data = 16'h5555;
      repeat (5) @(negedge clk);
      a_valid = 0; b_valid = 0;
      repeat (2) @(negedge clk);
      chk("t3_count", seen_src.size(), 5);
      for (int i = 0; i < 5 && i < seen_src.size(); i++)
         chk($sformatf("t3_src%0d", i), seen_src[i], exp3[i]);

      // backpressure
      a_valid = 1; a_data = 16'hDEAD; out_ready = 0;
      #3;
      chk("t4_accept", a_ready, 1);
      @(negedge clk);
      a_data = 16'h0101; b_valid = 1; b_data = 16'h1111;
      for (int i = 0; i < 5; i++) begin
         #3;
         chk("t4_hold_a_ready", a_ready, 0);
         chk("t4_hold_b_ready", b_ready, 0);
         chk("t4_hold_data", out_data, 16'hDEAD);
         @(negedge clk);
      end
      out_ready = 1;
      #3;
      chk("t4_release_a_ready", a_ready, 1);
      @(negedge clk);
      a_valid = 0;
      #1;
      chk("t4_next_data", out_data, 16'h0101);
      @(negedge clk);
      b_valid = 0;
      @(negedge clk);

      // burst yield: A,A,B,A
      do_reset();
      seen_src.delete();
      a_valid = 1; a_data = 16'hA001;
      @(negedge clk); a_data = 16'hA002; b_valid = 1; b_data = 16'hBEEF;
      @(negedge clk); a_data = 16'hA003;
      @(negedge clk); b_valid = 0;
      @(negedge clk); a_valid = 0;
      @(negedge clk);
      #3;
      chk("t5_count", seen_src.size(), 4);
      for (int i = 0; i < 4 && i < seen_src.size(); i++)
         chk($sformatf("t5_src%0d", i), seen_src[i], exp5[i]);

      // idle return after a B beat, then A wins the next contest
      @(negedge clk); b_valid = 1; b_data = 16'hB006;
      @(negedge clk); b_valid = 0;
      @(negedge clk);
      @(negedge clk);
      a_valid = 1; a_data = 16'hA008; b_valid = 1; b_data = 16'hB008;
      #3;
      chk("t6_a_first", a_ready, 1);
      chk("t6_b_wait", b_ready, 0);
      @(negedge clk); a_valid = 0;
      @(negedge clk); b_valid = 0;
      @(negedge clk);

      // randomized traffic with a mid-stream asynchronous reset
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (!a_valid || a_taken) begin
            a_valid = ($urandom_range(0, 99) < 60);
            a_data  = 16'($urandom);
         end
         if (!b_valid || b_taken) begin
            b_valid = ($urandom_range(0, 99) < 60);
            b_data  = 16'($urandom);
         end
         out_ready = ($urandom_range(0, 99) < 70);
         if (cyc == 1500) begin
            a_valid = 1; out_ready = 0;
            repeat (3) @(negedge clk);
            #1;
            chk("t1_pre_out_valid", out_valid, 1);
            chk_en = 0; rst_n = 0;
            #1;
            chk("t1_out_valid", out_valid, 0);
            chk("t1_out_data", out_data, 0);
            chk("t1_a_ready", a_ready, 0);
            chk("t1_b_ready", b_ready, 0);
            @(negedge clk);
            model_reset();
            rst_n = 1; chk_en = 1;
         end
      end

      // drain
      @(negedge clk);
      a_valid = 0; b_valid = 0; out_ready = 1;
      repeat (3) @(negedge clk);
      chk("drain_empty", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
